// File: rtl/loader_pkg.sv
// Shared types and helpers for the UART instruction-memory loader.
// The L_CSUM state is only reachable when UART_IMEM_LOADER_CHECKSUM_EN is defined.
package loader_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    L_LEN_HI,
    L_LEN_LO,
    L_DATA,
    L_CSUM,
    L_DONE,
    L_ERR
  } loader_state_e;

  function automatic int clks_per_bit(input int clk_freq_hz, input int baud);
    return clk_freq_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle
// rx_valid per good byte and one-cycle frame_err per bad stop bit.
module uart_rx_8n1
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);

  logic            rx_meta_q, rx_sync_q;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;

  // rx is asynchronous to clk; idle level is high so the flops reset to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      R_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_sync_q) state_d = R_START;
      end
      R_START: begin
        if (clk_cnt_q == HALF_BIT) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rx_sync_q ? R_IDLE : R_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      R_DATA: begin
        if (clk_cnt_q == FULL_BIT) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = R_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      R_STOP: begin
        if (clk_cnt_q == FULL_BIT) begin
          clk_cnt_d   = '0;
          rx_valid_d  = rx_sync_q;
          frame_err_d = !rx_sync_q;
          state_d     = R_IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= R_IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_valid  = rx_valid_q;
  assign rx_byte   = shift_q;
  assign frame_err = frame_err_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Loads a length-prefixed big-endian program image from UART into instruction memory.
// Optional trailing checksum byte enabled by UART_IMEM_LOADER_CHECKSUM_EN.
module uart_imem_loader
  import loader_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 50000000,
  parameter int BAUD           = 115200,
  parameter int ADDR_BUS_WIDTH = 16,
  parameter int MEM_BYTES      = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx,
  input  logic                      load_start,
  output logic                      we,
  output logic [ADDR_BUS_WIDTH-1:0] waddr,
  output logic [7:0]                wdata,
  output logic                      cpu_hold,
  output logic                      load_done,
  output logic                      err
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       frame_err;

  uart_rx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .frame_err(frame_err)
  );

  loader_state_e             state_q;
  logic [15:0]               len_q;
  logic [ADDR_BUS_WIDTH-1:0] cnt_q;
  logic                      we_q;
  logic [ADDR_BUS_WIDTH-1:0] waddr_q;
  logic [7:0]                wdata_q;
  logic                      cpu_hold_q;
  logic                      load_done_q;
  logic                      err_q;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
  logic [7:0]                sum_q;
`endif

  logic [15:0] len_full;
  logic [15:0] cnt_next16;
  assign len_full   = {len_q[15:8], rx_byte};
  assign cnt_next16 = 16'(cnt_q) + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= L_LEN_HI;
      len_q       <= '0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      cpu_hold_q  <= 1'b1;
      load_done_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state_q)
        L_LEN_HI: begin
          if (rx_valid) begin
            len_q[15:8] <= rx_byte;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
            sum_q       <= rx_byte;
`endif
            state_q     <= L_LEN_LO;
          end
        end
        L_LEN_LO: begin
          if (rx_valid) begin
            len_q[7:0] <= rx_byte;
            cnt_q      <= '0;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
            sum_q      <= sum_q + rx_byte;
`endif
            if (len_full == 16'd0) begin
              state_q     <= L_DONE;
              cpu_hold_q  <= 1'b0;
              load_done_q <= 1'b1;
            end else if ({16'd0, len_full} > 32'(MEM_BYTES)) begin
              err_q   <= 1'b1;
              state_q <= L_ERR;
            end else begin
              state_q <= L_DATA;
            end
          end
        end
        L_DATA: begin
          if (rx_valid) begin
            we_q    <= 1'b1;
            waddr_q <= cnt_q;
            wdata_q <= rx_byte;
            cnt_q   <= cnt_q + ADDR_BUS_WIDTH'(1);
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
            sum_q   <= sum_q + rx_byte;
            if (cnt_next16 == len_q) state_q <= L_CSUM;
`else
            if (cnt_next16 == len_q) begin
              state_q     <= L_DONE;
              cpu_hold_q  <= 1'b0;
              load_done_q <= 1'b1;
            end
`endif
          end
        end
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
        // A valid image sums (lengths + payload + checksum) to zero mod 256.
        L_CSUM: begin
          if (rx_valid) begin
            if (8'(sum_q + rx_byte) == 8'd0) begin
              state_q     <= L_DONE;
              cpu_hold_q  <= 1'b0;
              load_done_q <= 1'b1;
            end else begin
              err_q   <= 1'b1;
              state_q <= L_ERR;
            end
          end
        end
`endif
        L_DONE, L_ERR: begin
          if (load_start) begin
            err_q       <= 1'b0;
            cnt_q       <= '0;
            waddr_q     <= '0;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
            state_q     <= L_LEN_HI;
          end
        end
        default: state_q <= L_ERR;
      endcase
      // Framing errors abort an in-progress load; once idle they only flag.
      if (frame_err) begin
        err_q <= 1'b1;
        if (state_q != L_DONE && state_q != L_ERR) begin
          state_q     <= L_ERR;
          cpu_hold_q  <= 1'b1;
          load_done_q <= 1'b0;
        end
      end
    end
  end

  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign err       = err_q;

endmodule
